// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one fixed-latency main memory
// between the I-cache and D-cache miss paths, round-robin on ties.
module unified_mem_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int AW      = 14,
  parameter int DW      = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

  if (MEM_LAT < 2 || MEM_LAT > 15) begin : g_lat_chk
    $error("MEM_LAT out of range 2..15");
  end

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       last_d;
  logic       we_q;
  logic       fin;
  logic       gnt_i;
  logic       gnt_d;

  assign fin     = (cnt == LAST);
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  // grant decode in IDLE; on a tie the side not granted last wins
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (state == IDLE) begin
      unique case (1'b1)
        i_req & d_req: begin
          gnt_d = ~last_d;
          gnt_i = last_d;
        end
        i_req & ~d_req: gnt_i = 1'b1;
        ~i_req & d_req: gnt_d = 1'b1;
        default: ;
      endcase
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state: grant from IDLE, back to IDLE on the final cycle
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (gnt_i)      state_nxt = I_BUSY;
        else if (gnt_d) state_nxt = D_BUSY;
      end
      I_BUSY, D_BUSY: begin
        if (fin) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // outputs: memory strobes, done pulses and busy from state/cnt
  always_comb begin
    mem_re = 1'b0;
    mem_we = 1'b0;
    i_done = 1'b0;
    d_done = 1'b0;
    busy   = 1'b0;
    unique case (state)
      I_BUSY: begin
        mem_re = 1'b1;
        i_done = fin;
        busy   = 1'b1;
      end
      D_BUSY: begin
        mem_re = ~we_q;
        mem_we = we_q;
        d_done = fin;
        busy   = 1'b1;
      end
      default: ;
    endcase
  end

  // access cycle counter: held at zero while idle, counts busy cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             cnt <= 4'd0;
    else if (state == IDLE) cnt <= 4'd0;
    else                    cnt <= cnt + 4'd1;
  end

  // command latch: address/data/direction captured at grant only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_q      <= 1'b0;
    end else if (gnt_i) begin
      mem_addr  <= i_addr;
    end else if (gnt_d) begin
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
      we_q      <= d_we;
    end
  end

  // round-robin history; resets to I so the first tie goes to D
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     last_d <= 1'b0;
    else if (gnt_i) last_d <= 1'b0;
    else if (gnt_d) last_d <= 1'b1;
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: scoreboard bench, MEM_LAT=4 main instance
// plus a MEM_LAT=2 instance for back-to-back timing.
module tb_unified_mem_arbiter;

  typedef struct packed {
    logic        is_d;
    logic        we;
    logic [13:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic        i_req4 = 0, d_req4 = 0, d_we4 = 0;
  logic [13:0] i_addr4 = 0, d_addr4 = 0;
  logic [63:0] d_wdata4 = 0;
  logic        i_done4, d_done4, mem_re4, mem_we4, busy4;
  logic [63:0] i_rdata4, d_rdata4, mem_wdata4, mem_rdata4;
  logic [13:0] mem_addr4;

  logic        i_req2 = 0, d_req2 = 0, d_we2 = 0;
  logic [13:0] i_addr2 = 0, d_addr2 = 0;
  logic [63:0] d_wdata2 = 0;
  logic        i_done2, d_done2, mem_re2, mem_we2, busy2;
  logic [63:0] i_rdata2, d_rdata2, mem_wdata2, mem_rdata2;
  logic [13:0] mem_addr2;

  function automatic logic [63:0] mdata(input logic [13:0] a);
    if (a == 14'h0012) return 64'h1111_2222_3333_4444;
    return {2'b10, a, 2'b01, ~a, 2'b11, a, 2'b00, a ^ 14'h2a5a};
  endfunction

  assign mem_rdata4 = mdata(mem_addr4);
  assign mem_rdata2 = mdata(mem_addr2);

  unified_mem_arbiter #(.MEM_LAT(4), .AW(14), .DW(64)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req4), .i_addr(i_addr4),
    .i_done(i_done4), .i_rdata(i_rdata4),
    .d_req(d_req4), .d_we(d_we4), .d_addr(d_addr4),
    .d_wdata(d_wdata4),
    .d_done(d_done4), .d_rdata(d_rdata4),
    .mem_re(mem_re4), .mem_we(mem_we4),
    .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_rdata(mem_rdata4), .busy(busy4)
  );

  unified_mem_arbiter #(.MEM_LAT(2), .AW(14), .DW(64)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req2), .i_addr(i_addr2),
    .i_done(i_done2), .i_rdata(i_rdata2),
    .d_req(d_req2), .d_we(d_we2), .d_addr(d_addr2),
    .d_wdata(d_wdata2),
    .d_done(d_done2), .d_rdata(d_rdata2),
    .mem_re(mem_re2), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_rdata(mem_rdata2), .busy(busy2)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic sb_t mk(input logic is_d, input logic we,
                             input logic [13:0] a,
                             input logic [63:0] wd);
    sb_t e;
    e.is_d  = is_d;
    e.we    = we;
    e.addr  = a;
    e.wdata = wd;
    e.rdata = mdata(a);
    return e;
  endfunction

  sb_t sb4[$];
  sb_t e4;
  int  run4 = 0;
  int  idle4 = 0;
  bit  seen4 = 0;
  bit  gap_on = 0;

  // MEM_LAT=4 monitor: command checked every busy cycle vs scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      run4 = 0;
      idle4 = 0;
    end else if (busy4) begin
      if (run4 == 0 && gap_on && seen4) chk("gap", idle4, 1);
      run4++;
      idle4 = 0;
      if (sb4.size() == 0) begin
        chk("sb_empty", 1, 0);
      end else begin
        e4 = sb4[0];
        chk("addr", mem_addr4, e4.addr);
        chk("re", mem_re4, !e4.we);
        chk("we", mem_we4, e4.we);
        if (e4.we) chk("wdata", mem_wdata4, e4.wdata);
        if (i_done4 || d_done4) begin
          chk("who", d_done4, e4.is_d);
          chk("both", i_done4 & d_done4, 0);
          chk("len", run4, 4);
          if (!e4.we)
            chk("rdata", e4.is_d ? d_rdata4 : i_rdata4, e4.rdata);
          void'(sb4.pop_front());
        end
      end
    end else begin
      if (run4 != 0) seen4 = 1;
      run4 = 0;
      idle4++;
      chk("idle_out", {mem_re4, mem_we4, i_done4, d_done4}, 0);
    end
  end

  bit          lat2_on = 0;
  logic [13:0] exp_a2 = 14'h0123;
  int          run2 = 0;
  int          ndone2 = 0;
  int          cyc2 = 0;
  int          last2 = 0;

  // MEM_LAT=2 monitor: hold length, data and done spacing
  always @(negedge clk) begin
    cyc2++;
    if (rst_n && lat2_on) begin
      if (busy2) begin
        run2++;
        chk("l2_addr", mem_addr2, exp_a2);
        chk("l2_re", mem_re2, 1);
        chk("l2_we", mem_we2, 0);
        if (i_done2) begin
          chk("l2_len", run2, 2);
          chk("l2_data", i_rdata2, mdata(exp_a2));
          if (ndone2 > 0) chk("l2_period", cyc2 - last2, 3);
          last2 = cyc2;
          ndone2++;
        end
      end else begin
        run2 = 0;
        chk("l2_idle", {mem_re2, i_done2}, 0);
      end
    end
  end

  task automatic wait_done(input bit is_d, input int lim);
    bit hit = 0;
    for (int k = 0; k < lim && !hit; k++) begin
      @(negedge clk);
      hit = is_d ? d_done4 : i_done4;
    end
    if (!hit) chk("timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic i_read(input logic [13:0] a);
    sb4.push_back(mk(1'b0, 1'b0, a, 64'h0));
    i_req4 = 1;
    i_addr4 = a;
    wait_done(1'b0, 20);
    i_req4 = 0;
  endtask

  task automatic d_acc(input logic we, input logic [13:0] a,
                       input logic [63:0] wd);
    sb4.push_back(mk(1'b1, we, a, wd));
    d_req4 = 1;
    d_we4 = we;
    d_addr4 = a;
    d_wdata4 = wd;
    wait_done(1'b1, 20);
    d_req4 = 0;
    d_we4 = 0;
  endtask

  initial begin
    int n;
    #2 rst_n = 0;
    #1;
    chk("rst_re", mem_re4, 0);
    chk("rst_we", mem_we4, 0);
    chk("rst_addr", mem_addr4, 0);
    chk("rst_wdata", mem_wdata4, 0);
    chk("rst_done", {i_done4, d_done4}, 0);
    chk("rst_busy", busy4, 0);
    chk("rst_busy2", busy2, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // tie out of reset: D, I, D, I, one idle cycle apart
    seen4 = 0;
    gap_on = 1;
    sb4.push_back(mk(1'b1, 1'b0, 14'h0100, 64'h0));
    sb4.push_back(mk(1'b0, 1'b0, 14'h0200, 64'h0));
    sb4.push_back(mk(1'b1, 1'b0, 14'h0100, 64'h0));
    sb4.push_back(mk(1'b0, 1'b0, 14'h0200, 64'h0));
    d_addr4 = 14'h0100;
    i_addr4 = 14'h0200;
    d_we4 = 0;
    d_req4 = 1;
    i_req4 = 1;
    n = 0;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(negedge clk);
      if (i_done4 || d_done4) n++;
    end
    chk("tie_count", n, 4);
    @(posedge clk);
    #1;
    d_req4 = 0;
    i_req4 = 0;
    repeat (2) @(posedge clk);
    #1 gap_on = 0;

    i_read(14'h0012);
    @(posedge clk);
    #1;
    chk("busy_after", busy4, 0);

    d_acc(1'b1, 14'h0300, 64'hDEAD_BEEF_0123_4567);
    @(posedge clk);
    #1;

    // inputs wiggle mid-access; latched command must not move
    sb4.push_back(mk(1'b0, 1'b0, 14'h0040, 64'h0));
    i_req4 = 1;
    i_addr4 = 14'h0040;
    @(posedge clk);
    @(posedge clk);
    #1;
    i_addr4 = 14'h0050;
    d_we4 = ~d_we4;
    wait_done(1'b0, 20);
    i_req4 = 0;
    d_we4 = 0;
    @(posedge clk);
    #1;

    // reset at cnt==2 of a D read
    sb4.push_back(mk(1'b1, 1'b0, 14'h0777, 64'h0));
    d_req4 = 1;
    d_we4 = 0;
    d_addr4 = 14'h0777;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_re", mem_re4, 1);
    sb4.delete();
    rst_n = 0;
    #1;
    chk("mid_rst_re", mem_re4, 0);
    chk("mid_rst_busy", busy4, 0);
    d_req4 = 0;
    repeat (2) begin
      @(negedge clk);
      chk("mid_rst_done", d_done4, 0);
    end
    @(posedge clk);
    #1 rst_n = 1;
    d_acc(1'b0, 14'h0555, 64'h0);
    @(posedge clk);
    #1;

    // MEM_LAT=2 back-to-back I reads
    lat2_on = 1;
    i_addr2 = exp_a2;
    i_req2 = 1;
    for (int k = 0; k < 40 && ndone2 < 3; k++) @(negedge clk);
    chk("l2_count", ndone2, 3);
    @(posedge clk);
    #1 i_req2 = 0;
    repeat (3) @(posedge clk);
    #1 lat2_on = 0;

    chk("sb_left", sb4.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
